// File: rtl/framebuffer_reader.sv
// Framebuffer raster reader: scans the frame buffer in raster order, fetching
// one pixel per read strobe (one-cycle read latency) into a 2-entry FIFO whose
// head drives a valid/ready pixel stream.
// Optional feature: define FB_READER_UPSCALE2X_EN to emit every fetched pixel
// twice and scan every source row twice (2x nearest-neighbour upscale).

package framebuffer_reader_pkg;
    typedef logic [15:0] color_t;
`ifdef FB_READER_UPSCALE2X_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
endpackage

module framebuffer_reader
    import framebuffer_reader_pkg::*;
#(
    parameter int BUFFER_WIDTH      = 160,
    parameter int BUFFER_HEIGHT     = 120,
    parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
    localparam int OUT_WIDTH        = BUFFER_WIDTH * SCALE,
    localparam int OUT_HEIGHT       = BUFFER_HEIGHT * SCALE,
    localparam int OX_W             = $clog2(OUT_WIDTH),
    localparam int OY_W             = $clog2(OUT_HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read_start,
    output logic                         busy,
    output logic                         read_done,
    output logic                         read_en,
    output logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
    input  color_t                       read_data,
    output logic                         pixel_valid,
    input  logic                         pixel_ready,
    output color_t                       pixel_data,
    output logic [OX_W-1:0]              pixel_x,
    output logic [OY_W-1:0]              pixel_y,
    output logic                         pixel_last
);

    localparam int X_W = $clog2(BUFFER_WIDTH);

    typedef enum logic [1:0] {IDLE, READING, DRAINING} state_e;

    state_e                       state_q, state_d;
    logic [X_W-1:0]               x_q, x_d;
    logic [BUFFER_ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef FB_READER_UPSCALE2X_EN
    logic                         rep_q, rep_d;      // second pass over the current source row
`endif
    logic                         inflight_q, inflight_d;
    logic [1:0]                   count_q, count_d;
    color_t                       head_q, head_d;
    color_t                       tail_q, tail_d;
    logic [OX_W-1:0]              ox_q, ox_d;
    logic [OY_W-1:0]              oy_q, oy_d;

    logic       fire, pop, push, last_beat, rd_en, last_addr, row_end;
    logic [2:0] occupancy;

    // Handshake, pop and read-credit decisions
    always_comb begin
        fire      = pixel_valid && pixel_ready;
`ifdef FB_READER_UPSCALE2X_EN
        pop       = fire && ox_q[0];                  // pixel leaves only after its second beat
`else
        pop       = fire;
`endif
        push      = inflight_q;
        last_beat = (ox_q == OX_W'(OUT_WIDTH - 1)) && (oy_q == OY_W'(OUT_HEIGHT - 1));
        // Entries that will be held once everything already requested lands.
        occupancy = {1'b0, count_q} + 3'(inflight_q) - 3'(pop);
        rd_en     = (state_q == READING) && (occupancy < 3'd2);
        row_end   = (x_q == X_W'(BUFFER_WIDTH - 1));
`ifdef FB_READER_UPSCALE2X_EN
        last_addr = (addr_q == BUFFER_ADDR_WIDTH'(BUFFER_WIDTH * BUFFER_HEIGHT - 1)) && rep_q;
`else
        last_addr = (addr_q == BUFFER_ADDR_WIDTH'(BUFFER_WIDTH * BUFFER_HEIGHT - 1));
`endif
    end

    // Scan FSM and raster address generator
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        x_d     = x_q;
        addr_d  = addr_q;
`ifdef FB_READER_UPSCALE2X_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (read_start) state_d = READING;
            end
            READING: begin
                if (rd_en) begin
                    if (last_addr) begin
                        state_d = DRAINING;
                        x_d     = '0;
                        addr_d  = '0;
`ifdef FB_READER_UPSCALE2X_EN
                        rep_d   = 1'b0;
`endif
                    end else if (row_end) begin
                        x_d = '0;
`ifdef FB_READER_UPSCALE2X_EN
                        rep_d  = ~rep_q;
                        addr_d = rep_q ? addr_q + BUFFER_ADDR_WIDTH'(1)
                                       : addr_q - BUFFER_ADDR_WIDTH'(BUFFER_WIDTH - 1);
`else
                        addr_d = addr_q + BUFFER_ADDR_WIDTH'(1);
`endif
                    end else begin
                        x_d    = x_q + X_W'(1);
                        addr_d = addr_q + BUFFER_ADDR_WIDTH'(1);
                    end
                end
            end
            DRAINING: begin
                if (fire && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry FIFO (head/tail) and output coordinate counters
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        inflight_d = rd_en;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = read_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = read_data;
                end else if (push) begin
                    tail_d  = read_data;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                // Full: a push can only coincide with a pop, so the tail slides forward.
                if (pop) begin
                    head_d = tail_q;
                    if (push) tail_d = read_data;
                    else      count_d = 2'd1;
                end
            end
        endcase
        if (fire) begin
            if (ox_q == OX_W'(OUT_WIDTH - 1)) begin
                ox_d = '0;
                oy_d = last_beat ? '0 : oy_q + OY_W'(1);
            end else begin
                ox_d = ox_q + OX_W'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            addr_q     <= '0;
`ifdef FB_READER_UPSCALE2X_EN
            rep_q      <= 1'b0;
`endif
            inflight_q <= 1'b0;
            count_q    <= '0;
            // NOTE: FIFO storage is reset too, because pixel_data must read 0 after reset.
            head_q     <= '0;
            tail_q     <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            x_q        <= x_d;
            addr_q     <= addr_d;
`ifdef FB_READER_UPSCALE2X_EN
            rep_q      <= rep_d;
`endif
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign read_done   = (state_q == DRAINING) && fire && last_beat;
    assign read_en     = rd_en;
    assign read_addr   = addr_q;
    assign pixel_valid = (count_q != 2'd0);
    assign pixel_data  = head_q;
    assign pixel_x     = ox_q;
    assign pixel_y     = oy_q;
    assign pixel_last  = pixel_valid && last_beat;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Self-checking bench for framebuffer_reader: reset/latency vector table, a
// full frame at full rate, a randomly stalled frame cut by reset, and (default
// build) a full randomly stalled frame, all checked against a coordinate model.
module tb_framebuffer_reader;
    import framebuffer_reader_pkg::*;

    localparam int W      = 160;
    localparam int H      = 120;
    localparam int S      = SCALE;
    localparam int OW     = W * S;
    localparam int OH     = H * S;
    localparam int NBEATS = OW * OH;
    localparam int AW     = $clog2(W * H);
    localparam int OXW    = $clog2(OW);
    localparam int OYW    = $clog2(OH);

    logic           clk = 1'b0;
    logic           rst;
    logic           read_start;
    logic           busy;
    logic           read_done;
    logic           read_en;
    logic [AW-1:0]  read_addr;
    color_t         read_data;
    logic           pixel_valid;
    logic           pixel_ready;
    color_t         pixel_data;
    logic [OXW-1:0] pixel_x;
    logic [OYW-1:0] pixel_y;
    logic           pixel_last;

    framebuffer_reader dut (
        .clk         (clk),
        .rst         (rst),
        .read_start  (read_start),
        .busy        (busy),
        .read_done   (read_done),
        .read_en     (read_en),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_data  (pixel_data),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_last  (pixel_last)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    color_t key      = '0;

    // Reference model state: beats transferred, reads issued and pixels retired this frame.
    int   beat = 0, fetched = 0, popped = 0, done_cnt = 0;
    logic armed = 1'b0, rst_prev = 1'b0, prev_stall = 1'b0, done_now = 1'b0;
    logic pend_v = 1'b0;
    int   pend_a = 0;
    logic [$bits(color_t)+OXW+OYW:0] prev_beat = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic color_t data_of(input int a);
        return color_t'(a) ^ key;
    endfunction

    // j-th read of a frame: each source row is scanned S times in a row.
    function automatic int fetch_addr(input int j);
        return ((j / W) / S) * W + (j % W);
    endfunction

    // One clock cycle: drive inputs at the falling edge, sample and score outputs 1 time unit later.
    task automatic step(input logic rst_i, input logic rs_i, input int pct);
        int ox, oy;
        logic last;
        @(negedge clk);
        read_data   = pend_v ? data_of(pend_a) : color_t'($urandom);
        rst         = rst_i;
        read_start  = rs_i;
        pixel_ready = ($urandom_range(0, 99) < pct);
        #1;
        cyc++;
        done_now = 1'b0;
        pend_v   = (read_en === 1'b1);
        pend_a   = int'(read_addr);
        if (read_done === 1'b1) done_cnt++;
        if (rst_prev) begin
            armed = 1'b1;
            check("post_reset_outputs",
                  64'({busy, read_done, read_en, read_addr, pixel_valid, pixel_data,
                       pixel_x, pixel_y, pixel_last}), 64'd0);
        end else if (armed) begin
            if (prev_stall)
                check("stall_hold", 64'({pixel_valid, pixel_data, pixel_x, pixel_y, pixel_last}),
                      64'({1'b1, prev_beat}));
            if (read_en) begin
                check("read_addr", 64'(read_addr), 64'(fetch_addr(fetched)));
                check("read_en_while_busy", 64'(busy), 64'd1);
                fetched++;
            end
            if (pixel_valid && pixel_ready) begin
                ox   = beat % OW;
                oy   = beat / OW;
                last = (beat == NBEATS - 1);
                if ((beat % S) == S - 1) popped++;
                check("beat", 64'({pixel_data, pixel_x, pixel_y, pixel_last, read_done}),
                      64'({data_of((oy / S) * W + ox / S), OXW'(ox), OYW'(oy), last, last}));
                beat++;
                done_now = last;
            end else begin
                check("no_done_without_transfer", 64'(read_done), 64'd0);
            end
            check("outstanding_le_2", 64'((fetched - popped) <= 2), 64'd1);
            if (done_now) begin
                beat    = 0;
                fetched = 0;
                popped  = 0;
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_beat  = {pixel_data, pixel_x, pixel_y, pixel_last};
        end
        if (rst_i) begin
            beat       = 0;
            fetched    = 0;
            popped     = 0;
            prev_stall = 1'b0;
        end
        rst_prev = rst_i;
    endtask

    typedef struct {
        logic       rst;
        logic       rs;
        int         rdy_pct;
        logic [3:0] flags;   // {busy, read_en, pixel_valid, read_done}
        int         addr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int t0, dn;
        logic done_seen;

        rst = 1'b1; read_start = 1'b0; pixel_ready = 1'b0; read_data = '0;

        vecs[0]  = '{1'b1, 1'b0,   0, 4'b0000, 0};
        vecs[1]  = '{1'b1, 1'b1,   0, 4'b0000, 0};  // start during reset is lost
        vecs[2]  = '{1'b0, 1'b0,   0, 4'b0000, 0};
        vecs[3]  = '{1'b0, 1'b1,   0, 4'b0000, 0};  // accepted at this edge
        vecs[4]  = '{1'b0, 1'b0,   0, 4'b1100, 0};  // first read
        vecs[5]  = '{1'b0, 1'b0,   0, 4'b1100, 1};
        vecs[6]  = '{1'b0, 1'b0,   0, 4'b1010, 2};  // credit exhausted, sink stalled
        vecs[7]  = '{1'b0, 1'b0,   0, 4'b1010, 2};  // FIFO full
        vecs[8]  = '{1'b0, 1'b0, 100, 4'b1110, 2};  // pop frees a credit same cycle
        vecs[9]  = '{1'b1, 1'b0,   0, 4'b1010, 3};  // reset mid-frame
        vecs[10] = '{1'b0, 1'b0,   0, 4'b0000, 0};

        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].rs, vecs[i].rdy_pct);
            check($sformatf("vec%0d_flags", i), 64'({busy, read_en, pixel_valid, read_done}),
                  64'(vecs[i].flags));
            check($sformatf("vec%0d_addr", i), 64'(read_addr), 64'(vecs[i].addr));
        end

        // Frame A: sink always ready; latency, bubble-free streaming, ignored restarts.
        key = '0;
        dn  = done_cnt;
        t0  = cyc + 1;
        step(1'b0, 1'b1, 100);
        check("a_c0_busy", 64'({busy, read_en}), 64'd0);
        step(1'b0, 1'b0, 100);
        check("a_c1_read_en_addr", 64'({busy, read_en, read_addr}), 64'({2'b11, AW'(0)}));
        step(1'b0, 1'b0, 100);
        check("a_c2_valid", 64'(pixel_valid), 64'd0);
        step(1'b0, 1'b0, 100);
        check("a_c3_valid", 64'(pixel_valid), 64'd1);
        done_seen = 1'b0;
        for (int c = 4; c < NBEATS + 200 && !done_seen; c++) begin
            step(1'b0, (c == 100 || c == 5000), 100);
            done_seen = done_now;
        end
        check("a_done_seen", 64'(done_seen), 64'd1);
        check("a_done_cycle", 64'(cyc - t0), 64'(3 + NBEATS - 1));
        check("a_one_done", 64'(done_cnt - dn), 64'd1);

        // Frame B: restart right after read_done, 30% ready, reset after beat 500.
        key = color_t'($urandom);
        step(1'b0, 1'b1, 30);
        check("b_busy_fell", 64'(busy), 64'd0);
        for (int c = 0; c < 5000 && beat < 500; c++) step(1'b0, 1'b0, 30);
        check("b_reached_500", 64'(beat >= 500), 64'd1);
        dn = done_cnt;
        step(1'b1, 1'b0, 30);
        step(1'b0, 1'b0, 100);
        step(1'b0, 1'b0, 100);
        check("b_stale_data_ignored", 64'({busy, pixel_valid}), 64'd0);
        check("b_no_done_after_reset", 64'(done_cnt - dn), 64'd0);

`ifndef FB_READER_UPSCALE2X_EN
        // Frame C: full frame after the reset under random backpressure.
        key = color_t'($urandom);
        done_seen = 1'b0;
        step(1'b0, 1'b1, 70);
        for (int c = 0; c < 60000 && !done_seen; c++) begin
            step(1'b0, 1'b0, 70);
            done_seen = done_now;
        end
        check("c_done_seen", 64'(done_seen), 64'd1);
        check("c_one_done", 64'(done_cnt - dn), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/framebuffer_reader.md
FRAMEBUFFER_READER -- requirements
Module: framebuffer_reader

Interface
REQ-001 SHALL have parameter BUFFER_WIDTH, default 160, source pixels per row.
REQ-002 SHALL have parameter BUFFER_HEIGHT, default 120, source rows.
REQ-003 SHALL have parameter BUFFER_ADDR_WIDTH, default $clog2(BUFFER_WIDTH*BUFFER_HEIGHT), buffer address width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port read_start  input  1  one-cycle request to scan one frame.
REQ-007 SHALL have port busy  output  1  high from accepted read_start until the last beat transfers.
REQ-008 SHALL have port read_done  output  1  one-cycle pulse on the last beat's transfer.
REQ-009 SHALL have port read_en  output  1  buffer read strobe.
REQ-010 SHALL have port read_addr  output  BUFFER_ADDR_WIDTH  buffer address, y*BUFFER_WIDTH+x.
REQ-011 SHALL have port read_data  input  color_t  buffer data, valid the cycle after read_en.
REQ-012 SHALL have port pixel_valid  output  1  output beat valid.
REQ-013 SHALL have port pixel_ready  input  1  sink accepts beat.
REQ-014 SHALL have port pixel_data  output  color_t  pixel colour.
REQ-015 SHALL have port pixel_x / pixel_y  output  $clog2(output width/height)  output coordinates of current beat.
REQ-016 SHALL have port pixel_last  output  1  marks the final beat of the frame.

Function
REQ-017 SHALL implement FSM IDLE -> READING (read_start in IDLE) -> DRAINING (last address issued) -> IDLE (last beat transferred).
REQ-018 SHALL ignore read_start while not IDLE.
REQ-019 SHALL issue addresses in raster order: x 0..BUFFER_WIDTH-1, wrap x to 0 and increment y, ending at (BUFFER_WIDTH-1, BUFFER_HEIGHT-1).
REQ-020 SHALL assert read_en only in READING and only while (fifo occupancy + reads in flight - pop this cycle) < 2.
REQ-021 SHALL capture read_data into a 2-entry FIFO; pixel_* driven from the FIFO head register.
REQ-022 SHALL treat a beat as transferred when pixel_valid && pixel_ready on a rising edge.
REQ-023 SHALL hold pixel_data, pixel_x, pixel_y, pixel_last stable while pixel_valid && !pixel_ready.
REQ-024 SHALL not drop pixel_valid without a transfer.
REQ-025 SHALL, with pixel_ready held high, assert read_en in cycle N+1 after read_start in cycle N, pixel_valid from cycle N+3, and sustain one beat per cycle with no bubbles.
REQ-026 SHALL never overflow the FIFO under arbitrary pixel_ready patterns; a simultaneous push and pop at full occupancy SHALL be legal.
REQ-027 SHALL assert pixel_last only with the final beat; read_done SHALL pulse in the same cycle that beat transfers, busy SHALL fall the cycle after.
REQ-028 SHALL accept a read_start in the cycle immediately after read_done.

Reset
REQ-029 SHALL, on rst, force state IDLE, clear counters, FIFO, and in-flight count.
REQ-030 SHALL drive, during and after reset, busy=0, read_done=0, read_en=0, read_addr=0, pixel_valid=0, pixel_data=0, pixel_x=0, pixel_y=0, pixel_last=0.
REQ-031 SHALL, on reset mid-frame, discard the frame with no read_done pulse and ignore any read_data returned the following cycle.

Configuration
REQ-032 SHALL support macro FB_READER_UPSCALE2X_EN.
REQ-033 SHALL, with FB_READER_UPSCALE2X_EN defined, emit each fetched pixel as two consecutive beats (pixel_x = 2x, 2x+1) and scan each source row twice (pixel_y = 2y, 2y+1), giving 2*BUFFER_WIDTH x 2*BUFFER_HEIGHT beats; a fetched pixel SHALL be popped only after its second beat transfers.
REQ-034 SHALL, without the macro, emit exactly BUFFER_WIDTH*BUFFER_HEIGHT beats at source coordinates.

Verification
REQ-035 SHALL cover: buffer filled with data = addr; read_start, pixel_ready=1 -> 19200 beats, beat k data k, (x,y) = (k%160, k/160), read_done on beat 19199 only.
REQ-036 SHALL cover: read_start in cycle 0 -> read_en in cycle 1 with addr 0, first pixel_valid in cycle 3, no bubbles thereafter.
REQ-037 SHALL cover: random 30% pixel_ready -> no lost/duplicated beats, outputs stable while stalled, never more than 2 entries buffered.
REQ-038 SHALL cover: rst asserted after beat 500 -> all outputs 0 next cycle, no read_done; new read_start -> full frame from addr 0.
REQ-039 SHALL cover: read_start repeated while busy -> ignored, exactly one read_done.
REQ-040 SHALL cover: with FB_READER_UPSCALE2X_EN -> 76800 beats, beats (0,0),(1,0) carry addr 0 data, row 1 repeats row 0 data, pixel_last at (319,239).
